// File: rtl/icache_loader_pkg.sv
// ============================================================================
// Module   : icache_loader_pkg
// Brief    : Shared state encoding and sizing constants for the program loader.
// Revision : 1.0
// ============================================================================
`default_nettype none

package icache_loader_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int DEFAULT_DEPTH  = 32;
    localparam int LANE_W         = $clog2(BYTES_PER_WORD);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/icache_loader_packer.sv
// ============================================================================
// Module   : byte_packer
// Brief    : Little-endian byte-lane assembly with a word-complete pulse.
// Revision : 1.0
// ============================================================================
`default_nettype none

module byte_packer
    import icache_loader_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_clear,
    input  logic                          i_fire,
    input  logic [7:0]                    i_byte,
    output logic [8*BYTES_PER_WORD-1:0]   o_word,
    output logic                          o_word_done
);

    localparam logic [LANE_W-1:0] c_LAST_LANE = LANE_W'(BYTES_PER_WORD - 1);

    logic [LANE_W-1:0]                 r_lane;
    logic [8*(BYTES_PER_WORD-1)-1:0]   r_bytes;

    // Earlier bytes shift down so the completing byte lands in the top lane.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_lane  <= '0;
            r_bytes <= '0;
        end else if (i_fire) begin
            r_lane  <= r_lane + 1'b1;
            r_bytes <= {i_byte, r_bytes[8*(BYTES_PER_WORD-1)-1:8]};
        end
    end

    assign o_word      = {i_byte, r_bytes};
    assign o_word_done = i_fire && (r_lane == c_LAST_LANE);

endmodule

`default_nettype wire

// File: rtl/icache_loader.sv
// ============================================================================
// Module   : icache_loader
// Brief    : Streams program bytes into 32-bit instruction-store writes.
// Revision : 1.0
// ============================================================================
`default_nettype none

module icache_loader
    import icache_loader_pkg::*;
#(
    parameter int          DEPTH     = DEFAULT_DEPTH,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [5:0]  len,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        wr_en,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        busy,
    output logic        done
);

    localparam int c_CW = ($clog2(DEPTH + 1) > 6) ? $clog2(DEPTH + 1) : 6;
    localparam logic [c_CW-1:0] c_DEPTH = c_CW'(DEPTH);

    state_t             r_state;
    state_t             w_next;
    logic [c_CW-1:0]    r_word_idx;
    logic [c_CW-1:0]    r_last_idx;
    logic [c_CW-1:0]    w_len_ext;
    logic [c_CW-1:0]    w_len_clamped;
    logic               w_start_ok;
    logic               w_fire;
    logic               w_word_done;
    logic               w_last_word;
    logic [31:0]        w_word;

    assign w_len_ext     = c_CW'(len);
    assign w_len_clamped = (w_len_ext > c_DEPTH) ? c_DEPTH : w_len_ext;
    assign w_start_ok    = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_fire        = byte_valid && byte_ready;
    assign w_last_word   = w_word_done && (r_word_idx == r_last_idx);

    assign byte_ready = (r_state == ST_LOAD);
    assign busy       = (r_state == ST_LOAD) || (r_state == ST_FLUSH);
    assign done       = (r_state == ST_DONE);

    byte_packer u_packer (
        .clk         (clock),
        .rst         (reset),
        .i_clear     (w_start_ok),
        .i_fire      (w_fire),
        .i_byte      (byte_data),
        .o_word      (w_word),
        .o_word_done (w_word_done)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (w_start_ok) begin
                    w_next = (len == 6'd0) ? ST_DONE : ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (w_last_word) begin
                    w_next = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                w_next = ST_DONE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Write port is registered: the strobe follows the completing byte by one cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_word_idx <= '0;
            r_last_idx <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
        end else begin
            wr_en <= 1'b0;
            if (w_start_ok) begin
                r_word_idx <= '0;
                r_last_idx <= w_len_clamped - 1'b1;
            end else if (w_word_done) begin
                wr_en      <= 1'b1;
                wr_data    <= w_word;
                wr_addr    <= BASE_ADDR + (32'(r_word_idx) << 2);
                r_word_idx <= r_word_idx + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire
